mt_ctrl: RTL and testbench

- Sequencer for the MT19937 624-word state memory: runs seeding, in-place twisting and tempered output generation.
- Drives the memory's seed and twist write ports and its three combinational read ports.
- Presents a 32-bit random-number stream on a valid/ready interface to downstream consumers.

---
 rtl/mt_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mt_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mt_ctrl.sv
// MT19937 sequencer: seeds, twists in place and streams tempered words from an external 624x32 state memory.
// Optional MT_AUTO_SEED_EN: seed with DEFAULT_SEED on the first cycle after reset, no handshake needed.
module mt_ctrl #(
  parameter int          N            = 624,
  parameter int          M            = 397,
  parameter logic [31:0] DEFAULT_SEED = 32'd5489
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic [31:0] seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        write_en_seed,
  output logic [9:0]  write_addr_seed,
  output logic [31:0] write_data_seed,
  output logic        write_en_twist,
  output logic [9:0]  write_addr_twist,
  output logic [31:0] write_data_twist,
  output logic [9:0]  read_addr1,
  output logic [9:0]  read_addr2,
  output logic [9:0]  read_addr3,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] read_data3
);

  localparam int            AW      = 10;
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-1:0] END_IDX = AW'(N);
  localparam logic [31:0]   MAG     = 32'h9908B0DF;

`ifdef MT_AUTO_SEED_EN
  localparam logic AUTO_SEED = 1'b1;
`else
  localparam logic AUTO_SEED = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_TWIST, S_OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   prev_q, prev_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          auto_q, auto_d;

  logic          seed_fire;
  logic [31:0]   seed_next;
  logic [31:0]   twist_y;
  logic [AW-1:0] addr_p1, addr_pm;
  logic [AW:0]   sum_pm;
  logic          unused_msb;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  assign seed_ready = (state_q == S_IDLE) || (state_q == S_OUTPUT);
  assign busy       = (state_q == S_SEED) || (state_q == S_TWIST);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign seed_fire  = seed_valid && seed_ready;

  // Seeding recurrence runs off the previous word held locally, never the memory.
  assign seed_next  = 32'd1812433253 * (prev_q ^ (prev_q >> 30)) + 32'(idx_q);

  assign addr_p1    = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign sum_pm     = {1'b0, idx_q} + (AW+1)'(M);
  assign addr_pm    = (sum_pm >= (AW+1)'(N)) ? AW'(sum_pm - (AW+1)'(N)) : sum_pm[AW-1:0];
  assign twist_y    = {read_data1[31], read_data2[30:0]};
  assign unused_msb = read_data2[31];

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    prev_d           = prev_q;
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    auto_d           = 1'b0;
    write_en_seed    = 1'b0;
    write_addr_seed  = '0;
    write_data_seed  = '0;
    write_en_twist   = 1'b0;
    write_addr_twist = '0;
    write_data_twist = '0;
    read_addr1       = '0;
    read_addr2       = '0;
    read_addr3       = '0;

    case (state_q)
      S_IDLE: begin
        if (seed_fire) begin
          state_d = S_SEED;
          idx_d   = '0;
          prev_d  = seed;
        end else if (auto_q) begin
          state_d = S_SEED;
          idx_d   = '0;
          prev_d  = DEFAULT_SEED;
        end
      end

      S_SEED: begin
        write_en_seed   = 1'b1;
        write_addr_seed = idx_q;
        write_data_seed = (idx_q == '0) ? prev_q : seed_next;
        prev_d          = write_data_seed;
        if (idx_q == LAST) begin
          state_d = S_TWIST;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_TWIST: begin
        read_addr1       = idx_q;
        read_addr2       = addr_p1;
        read_addr3       = addr_pm;
        write_en_twist   = 1'b1;
        write_addr_twist = idx_q;
        write_data_twist = read_data3 ^ (twist_y >> 1) ^ (twist_y[0] ? MAG : 32'h0);
        if (idx_q == LAST) begin
          state_d = S_OUTPUT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        read_addr1 = (idx_q == END_IDX) ? '0 : idx_q;
        if (seed_fire) begin
          // Reseed drops any word still sitting in the output register.
          state_d     = S_SEED;
          idx_d       = '0;
          prev_d      = seed;
          out_valid_d = 1'b0;
        end else if ((!out_valid_q || out_ready) && (idx_q != END_IDX)) begin
          out_data_d  = temper(read_data1);
          out_valid_d = 1'b1;
          idx_d       = idx_q + 1'b1;
        end else begin
          if (out_ready) out_valid_d = 1'b0;
          // Twist only once the last word has left, so the stream never skips.
          if ((idx_q == END_IDX) && (!out_valid_q || out_ready)) begin
            state_d = S_TWIST;
            idx_d   = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      auto_q      <= AUTO_SEED;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_q      <= prev_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      auto_q      <= auto_d;
    end
  end

endmodule

// File: tb/tb_mt_ctrl.sv
// Bench for mt_ctrl: models the 624-word state memory and checks the stream against a plain MT19937 model.
module tb_mt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid, seed_ready, out_valid, out_ready, busy;
  logic [31:0] seed, out_data;
  logic        write_en_seed, write_en_twist;
  logic [9:0]  write_addr_seed, write_addr_twist, read_addr1, read_addr2, read_addr3;
  logic [31:0] write_data_seed, write_data_twist, read_data1, read_data2, read_data3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_word = '0;
  int          lat, bcnt;

  logic [31:0] mem [0:623];
  logic [31:0] mt  [0:623];
  int          mti = 624;

  always #5 clk = ~clk;

  mt_ctrl dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
    .write_en_seed(write_en_seed), .write_addr_seed(write_addr_seed), .write_data_seed(write_data_seed),
    .write_en_twist(write_en_twist), .write_addr_twist(write_addr_twist), .write_data_twist(write_data_twist),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_addr3(read_addr3),
    .read_data1(read_data1), .read_data2(read_data2), .read_data3(read_data3)
  );

  always @(posedge clk) begin
    if (write_en_seed  && write_addr_seed  < 10'd624) mem[write_addr_seed]  <= write_data_seed;
    if (write_en_twist && write_addr_twist < 10'd624) mem[write_addr_twist] <= write_data_twist;
  end
  assign read_data1 = (read_addr1 < 10'd624) ? mem[read_addr1] : 32'h0;
  assign read_data2 = (read_addr2 < 10'd624) ? mem[read_addr2] : 32'h0;
  assign read_data3 = (read_addr3 < 10'd624) ? mem[read_addr3] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst) chk("we_excl", 32'(write_en_seed & write_en_twist), 32'd0);

  // Reference generator: the textbook init_genrand / genrand_int32.
  task automatic ref_seed(input logic [31:0] s);
    mt[0] = s;
    for (int i = 1; i < 624; i++)
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    mti = 624;
  endtask

  task automatic ref_next(output logic [31:0] r);
    logic [31:0] y;
    if (mti >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = {mt[k][31], mt[(k+1)%624][30:0]};
        mt[k] = mt[(k+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    r = y;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_srdy"},  32'(seed_ready), 32'd1);
    chk({tag, "_we"},    32'(write_en_seed | write_en_twist), 32'd0);
    chk({tag, "_addr"},  32'(write_addr_seed | write_addr_twist | read_addr1 | read_addr2 | read_addr3), 32'd0);
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic seed_accept(input logic [31:0] s, input bit hold);
    int w = 0;
    while (!seed_ready && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (!seed_ready) chk("seed_rdy_timeout", 32'(seed_ready), 32'd1);
    seed = s; seed_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) seed = 32'hDEADBEEF;
    else seed_valid = 1'b0;
  endtask

  task automatic wait_valid(output int l, output int b, input int hold);
    out_ready = 1'b0;
    b = (busy && !seed_ready) ? 1 : 0;
    l = 0;
    while (!out_valid && l < 3000) begin
      if (l >= hold) seed_valid = 1'b0;
      @(posedge clk); #1; l++;
      if (busy && !seed_ready) b++;
    end
    seed_valid = 1'b0;
  endtask

  task automatic run_words(input int n, input bit rnd);
    int          got = 0, cyc = 0;
    int          budget = 2*n + (n/624 + 2)*700 + 100;
    bit          stall = 1'b0, r;
    logic [31:0] pd = '0, e;
    while (got < n && cyc < budget) begin
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, pd);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        ref_next(e);
        chk("word", out_data, e);
        last_word = out_data;
        got++;
      end
      stall = out_valid && !r;
      pd = out_data;
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
    if (got < n) chk("words_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    seed_valid = 1'b0; seed = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

`ifdef MT_AUTO_SEED_EN
    wait_valid(lat, bcnt, 0);
    chk("auto_lat", 32'(lat), 32'd1250);
    ref_seed(32'd5489);
    run_words(1, 1'b0);
    chk("auto_w0", last_word, 32'hD091BB5C);
`else
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_srdy", 32'(seed_ready), 32'd1);
`endif

    // Seed 5489, full-rate stream up to word 10000
    seed_accept(32'd5489, 1'b0);
    chk("s5489_v0", 32'(out_valid), 32'd0);
    wait_valid(lat, bcnt, 0);
    chk("s5489_lat", 32'(lat), 32'd1249);
    chk("s5489_busy", 32'(bcnt), 32'd1248);
    ref_seed(32'd5489);
    run_words(1, 1'b0);
    chk("s5489_w0", last_word, 32'hD091BB5C);
    run_words(1, 1'b0);
    chk("s5489_w1", last_word, 32'h22AE9EF6);
    run_words(9998, 1'b0);
    chk("s5489_w9999", last_word, 32'd4123659995);

    // Reseed with 1 while in OUTPUT
    seed_accept(32'd1, 1'b0);
    chk("s1_v0", 32'(out_valid), 32'd0);
    wait_valid(lat, bcnt, 0);
    chk("s1_lat", 32'(lat), 32'd1249);
    chk("s1_busy", 32'(bcnt), 32'd1248);
    ref_seed(32'd1);
    run_words(1, 1'b0);
    chk("s1_w0", last_word, 32'd1791095845);

    // Random backpressure across several twist gaps
    seed_accept(32'd5489, 1'b0);
    wait_valid(lat, bcnt, 0);
    ref_seed(32'd5489);
    run_words(2000, 1'b1);

    // Reseed after 10 words; seed_valid left high during SEED must be ignored
    seed_accept(32'd7, 1'b0);
    wait_valid(lat, bcnt, 0);
    ref_seed(32'd7);
    run_words(10, 1'b1);
    seed_accept(32'd1, 1'b1);
    chk("reseed_v0", 32'(out_valid), 32'd0);
    wait_valid(lat, bcnt, 6);
    chk("reseed_lat", 32'(lat), 32'd1249);
    ref_seed(32'd1);
    run_words(1, 1'b0);
    chk("reseed_w0", last_word, 32'd1791095845);
    run_words(50, 1'b1);

    // Reset in the middle of TWIST
    seed_accept(32'd99, 1'b0);
    repeat (900) @(posedge clk);
    #1;
    chk("twist_busy", 32'(busy), 32'd1);
    chk("twist_we", 32'(write_en_twist), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    seed_accept(32'd5489, 1'b0);
    wait_valid(lat, bcnt, 0);
    chk("post_rst_lat", 32'(lat), 32'd1249);
    ref_seed(32'd5489);
    run_words(1, 1'b0);
    chk("post_rst_w0", last_word, 32'hD091BB5C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
